// File: rtl/shared_pkg.sv
// Shared definitions for the SPI slave front end: FSM state codes and the
// two-bit control field carried in rx_data[9:8].
package shared_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t CHK_CMD   = 3'd1;
  localparam state_t WRITE     = 3'd2;
  localparam state_t READ_ADD  = 3'd3;
  localparam state_t READ_DATA = 3'd4;

  // Control field of a received word; passed through to the RAM untouched.
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } ctrl_e;

endpackage

// File: rtl/spi_slave_if_if.sv
// Bundle of SPI pins plus the RAM-side word/read-data handshake.
interface spi_slave_if_if #(
  parameter int unsigned RX_WIDTH = 10,
  parameter int unsigned TX_WIDTH = 8
);
  logic                SS_n;
  logic                MOSI;
  logic                MISO;
  logic [RX_WIDTH-1:0] rx_data;
  logic                rx_valid;
  logic [TX_WIDTH-1:0] tx_data;
  logic                tx_valid;

  // View of the SPI slave block itself.
  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  // View of the SPI master / RAM side driving the slave.
  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_tx_serializer.sv
// MSB-first parallel-to-serial shifter for read data returned by the RAM.
// MISO is forced low whenever no word is being shifted out.
module spi_tx_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  output logic             miso
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;

  // Load, then shift one bit per cycle until WIDTH bits have been presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (clear) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      sh_q   <= data;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LastCnt) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign miso = busy_q & sh_q[WIDTH-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: frames 10-bit MOSI words for the RAM and serializes
// RAM read data back on MISO after a read-data command.
module spi_slave_if
  import shared_pkg::*;
#(
  parameter int unsigned RX_WIDTH = 10,
  parameter int unsigned TX_WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  spi_slave_if_if.slave  bus
);

  // Index of the counter value at which bit 0 of the frame is sampled.
  localparam logic [3:0] LastBit = 4'(RX_WIDTH - 2);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [RX_WIDTH-1:0] shift_q, shift_d;
  logic [RX_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rd_addr_seen_q, rd_addr_seen_d;
  // Frame fully received; block now holds until SS_n rises.
  logic                done_q, done_d;
  // Read-data frame complete, waiting for the RAM's first tx_valid.
  logic                wait_tx_q, wait_tx_d;
  logic                tx_load;
  logic                tx_clear;

  // Next-state and datapath decisions for the framing FSM.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    done_d         = done_q;
    wait_tx_d      = wait_tx_q;
    tx_load        = 1'b0;
    tx_clear       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        done_d    = 1'b0;
        wait_tx_d = 1'b0;
        if (!bus.SS_n) begin
          state_d = CHK_CMD;
        end
      end

      CHK_CMD: begin
        if (bus.SS_n) begin
          state_d = IDLE;
        end else begin
          shift_d = {{(RX_WIDTH-1){1'b0}}, bus.MOSI};
          cnt_d   = '0;
          if (!bus.MOSI) begin
            state_d = WRITE;
          end else if (!rd_addr_seen_q) begin
            state_d = READ_ADD;
          end else begin
            state_d = READ_DATA;
          end
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) begin
          // Abort: drop the partial frame, leave rd_addr_seen alone.
          state_d   = IDLE;
          cnt_d     = '0;
          done_d    = 1'b0;
          wait_tx_d = 1'b0;
          tx_clear  = 1'b1;
        end else if (!done_q) begin
          shift_d = {shift_q[RX_WIDTH-2:0], bus.MOSI};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LastBit) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_d;
            done_d     = 1'b1;
            cnt_d      = '0;
            if (state_q == READ_ADD) begin
              rd_addr_seen_d = 1'b1;
            end
            if (state_q == READ_DATA) begin
              rd_addr_seen_d = 1'b0;
              wait_tx_d      = 1'b1;
            end
          end
        end else if (wait_tx_q && bus.tx_valid) begin
          tx_load   = 1'b1;
          wait_tx_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      done_q         <= 1'b0;
      wait_tx_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      done_q         <= done_d;
      wait_tx_q      <= wait_tx_d;
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  spi_tx_serializer #(
    .WIDTH(TX_WIDTH)
  ) u_tx_serializer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tx_load),
    .clear (tx_clear),
    .data  (bus.tx_data),
    .miso  (bus.MISO)
  );

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomized self-checking bench for spi_slave_if against a frame-level model.
module tb_spi_slave_if;
  import shared_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_slave_if_if #(.RX_WIDTH(10), .TX_WIDTH(8)) bus ();

  spi_slave_if #(
    .RX_WIDTH(10),
    .TX_WIDTH(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  // Model: has a read address been accepted since the last read-data frame?
  bit rd_flag = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SPI transaction. abort_at: bit ordinal (0..9) at which SS_n rises, -1 none.
  // rst_bit: during read-data shift-out, assert rst_n before presenting this bit, -1 none.
  task automatic send_frame(input logic [9:0] f, input int abort_at, input logic [7:0] txd,
                            input int tx_delay, input int rst_bit);
    int     kind;
    state_t exp_state;
    bus.SS_n     = 1'b0;
    bus.MOSI     = 1'($urandom);
    bus.tx_valid = 1'($urandom);
    tick();
    for (int k = 0; k < 10; k++) begin
      bus.MOSI     = f[9-k];
      bus.tx_valid = 1'($urandom);
      bus.tx_data  = 8'($urandom);
      if (k == abort_at) begin
        bus.SS_n = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        check_eq("abort_rx_valid", 32'(bus.rx_valid), 0);
        check_eq("abort_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("abort_miso", 32'(bus.MISO), 0);
        return;
      end
      tick();
      if (k < 9) check_eq("rx_valid_early", 32'(bus.rx_valid), 0);
    end

    // 0 = write, 1 = read address, 2 = read data
    kind = !f[9] ? 0 : (rd_flag ? 2 : 1);
    exp_state = (kind == 0) ? WRITE : ((kind == 1) ? READ_ADD : READ_DATA);
    check_eq("rx_valid", 32'(bus.rx_valid), 1);
    check_eq("rx_data", 32'(bus.rx_data), 32'(f));
    check_eq("frame_state", 32'(dut.state_q), 32'(exp_state));
    check_eq("miso_rx", 32'(bus.MISO), 0);
    if (kind == 1) rd_flag = 1'b1;
    if (kind == 2) rd_flag = 1'b0;

    bus.tx_valid = (kind == 2) ? 1'b0 : 1'($urandom);
    tick();
    check_eq("rx_valid_pulse", 32'(bus.rx_valid), 0);
    check_eq("rx_data_hold", 32'(bus.rx_data), 32'(f));

    if (kind == 2) begin
      bus.tx_valid = 1'b0;
      for (int d = 0; d < tx_delay; d++) begin
        check_eq("miso_wait", 32'(bus.MISO), 0);
        tick();
      end
      bus.tx_valid = 1'b1;
      bus.tx_data  = txd;
      tick();
      for (int b = 7; b >= 0; b--) begin
        if (b == rst_bit) begin
          #2 rst_n = 1'b0;
          #1;
          check_eq("rst_miso", 32'(bus.MISO), 0);
          check_eq("rst_rx_valid", 32'(bus.rx_valid), 0);
          check_eq("rst_rx_data", 32'(bus.rx_data), 0);
          rd_flag      = 1'b0;
          bus.SS_n     = 1'b1;
          bus.tx_valid = 1'b0;
          tick();
          rst_n = 1'b1;
          tick();
          check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
          return;
        end
        check_eq("miso_bit", 32'(bus.MISO), 32'(txd[b]));
        bus.tx_valid = 1'($urandom);
        bus.tx_data  = 8'($urandom);
        tick();
      end
      check_eq("miso_after", 32'(bus.MISO), 0);
    end else begin
      for (int h = 0; h < 2; h++) begin
        check_eq("miso_hold", 32'(bus.MISO), 0);
        check_eq("hold_state", 32'(dut.state_q), 32'(exp_state));
        bus.tx_valid = 1'($urandom);
        tick();
      end
    end

    bus.tx_valid = 1'b0;
    bus.SS_n     = 1'b1;
    tick();
    check_eq("end_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("end_miso", 32'(bus.MISO), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] f;
    int         ab;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    #12;
    check_eq("reset_rx_valid", 32'(bus.rx_valid), 0);
    check_eq("reset_rx_data", 32'(bus.rx_data), 0);
    check_eq("reset_miso", 32'(bus.MISO), 0);
    check_eq("reset_state", 32'(dut.state_q), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    // Write frame with a plain payload.
    send_frame(10'h03C, -1, 8'h00, 1, -1);
    // Read address then read data returning 0xC3.
    send_frame(10'h2A5, -1, 8'h00, 1, -1);
    send_frame(10'h300, -1, 8'hC3, 2, -1);
    // Flag was cleared by the read-data frame: next read goes to READ_ADD.
    send_frame(10'h311, -1, 8'h00, 1, -1);
    send_frame(10'h322, -1, 8'h5A, 1, -1);
    // Abort after 5 bits, then a clean frame.
    send_frame(10'h1FF, 5, 8'h00, 1, -1);
    send_frame(10'h0AA, -1, 8'h00, 1, -1);
    // SS_n rising together with the final bit still aborts.
    send_frame(10'h155, 9, 8'h00, 1, -1);
    // Reset during shift-out clears the read-address flag.
    send_frame(10'h2F0, -1, 8'h00, 1, -1);
    send_frame(10'h3F0, -1, 8'h96, 1, 4);
    send_frame(10'h301, -1, 8'h00, 1, -1);

    for (int i = 0; i < 40; i++) begin
      f  = 10'($urandom);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1;
      send_frame(f, ab, 8'($urandom), int'($urandom_range(1, 3)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
